// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller and its 7-segment scan.
package data_mem_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_HALF = 1'b1;

  localparam logic [15:0] LED_BASE_DEF = 16'h2000;
endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a core and the data-memory controller.
interface data_mem_ctrl_if;
  logic        req;
  logic        we;
  logic        size;
  logic        sext;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [15:0] rdata;
  logic        err;

  modport master (output req, we, size, sext, addr, wdata,
                  input  ready, rvalid, rdata, err);
  modport slave  (input  req, we, size, sext, addr, wdata,
                  output ready, rvalid, rdata, err);
endinterface

// File: rtl/data_mem_ctrl_seg_scan.sv
// Multiplexed display scan: steps one digit every SCAN_DIV clocks, registered select/value.
module seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_DIGITS-1:0][3:0] digits_i,
  output logic [NUM_DIGITS-1:0]      dig_sel_o,
  output logic [3:0]                 dig_val_o
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [3:0]            val_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == DW'(NUM_DIGITS - 1)) ? '0 : idx_q + DW'(1);
    end
    sel_d        = '0;
    sel_d[idx_d] = 1'b1;
  end

  // Select and value are taken from the next index so both switch together.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      sel_q    <= '0;
      sel_q[0] <= 1'b1;
      val_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sel_q <= sel_d;
      val_q <= digits_i[idx_d];
    end
  end

  assign dig_sel_o = sel_q;
  assign dig_val_o = val_q;
endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable RAM plus memory-mapped display digits behind a two-phase req/rvalid bus.
//   state | meaning
//   IDLE  | ready, accepts a request; writes and read capture happen on the accept edge
//   RESP  | rvalid/err/rdata presented for one cycle, inputs ignored
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_BYTES = 256,
  parameter logic [15:0] LED_BASE    = LED_BASE_DEF,
  parameter int          NUM_DIGITS  = 4,
  parameter int          SCAN_DIV    = 1000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  data_mem_ctrl_if.slave        bus,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic [3:0]            dig_val
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t                     state_q, state_d;
  logic [7:0]                 mem [DEPTH_BYTES];
  logic [NUM_DIGITS-1:0][3:0] digits_q;
  logic [15:0]                rdata_q, rdata_d;
  logic                       err_q;

  logic          accept, misalign, lo_ram, lo_led, hi_led, bad, wr_en;
  logic [15:0]   led_off, led_off_hi;
  logic [AW-1:0] ram_lo, ram_hi;
  logic [DW-1:0] dig_lo, dig_hi;
  logic [7:0]    byte_lo, byte_hi;

  assign led_off    = bus.addr - LED_BASE;
  assign led_off_hi = led_off + 16'd1;
  assign ram_lo     = bus.addr[AW-1:0];
  assign ram_hi     = ram_lo + AW'(1);
  assign dig_lo     = led_off[DW-1:0];
  assign dig_hi     = led_off_hi[DW-1:0];

  // Addresses below LED_BASE wrap led_off to a large value, so one compare covers both bounds.
  assign lo_ram   = {16'b0, bus.addr} < 32'(DEPTH_BYTES);
  assign lo_led   = led_off < 16'(NUM_DIGITS);
  assign hi_led   = led_off_hi < 16'(NUM_DIGITS);
  assign misalign = (bus.size == SZ_HALF) && bus.addr[0];
  assign bad      = misalign || (!lo_ram && !lo_led);
  assign accept   = bus.req && (state_q == IDLE);
  assign wr_en    = accept && bus.we && !bad;

  always_comb begin
    byte_lo = lo_ram ? mem[ram_lo] : {4'h0, digits_q[dig_lo]};
    byte_hi = lo_ram ? mem[ram_hi] : (hi_led ? {4'h0, digits_q[dig_hi]} : 8'h00);
    rdata_d = 16'h0000;
    if (!bad) begin
      if (bus.size == SZ_HALF)    rdata_d = {byte_hi, byte_lo};
      else if (bus.sext && lo_ram) rdata_d = {{8{byte_lo[7]}}, byte_lo};
      else                         rdata_d = {8'h00, byte_lo};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      digits_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rdata_q <= rdata_d;
        err_q   <= bad;
      end
      if (wr_en && !lo_ram) begin
        digits_q[dig_lo] <= bus.wdata[3:0];
        if ((bus.size == SZ_HALF) && hi_led) digits_q[dig_hi] <= bus.wdata[11:8];
      end
    end
  end

  // RAM has no reset; contents survive RESET.
  always_ff @(posedge CLK) begin
    if (wr_en && lo_ram) begin
      mem[ram_lo] <= bus.wdata[7:0];
      if (bus.size == SZ_HALF) mem[ram_hi] <= bus.wdata[15:8];
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.rvalid = (state_q == RESP);
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q && (state_q == RESP);

  seg_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_seg_scan (
    .CLK       (CLK),
    .RESET     (RESET),
    .digits_i  (digits_q),
    .dig_sel_o (dig_sel),
    .dig_val_o (dig_val)
  );
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised bench for data_mem_ctrl against an array-based memory/display model.
module tb_data_mem_ctrl;
  localparam int          DEPTH = 256;
  localparam int          ND    = 4;
  localparam int          SD    = 4;
  localparam logic [15:0] LB    = 16'h2000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_ctrl_if bus ();
  logic [ND-1:0] dig_sel;
  logic [3:0]    dig_val;

  data_mem_ctrl #(
    .DEPTH_BYTES (DEPTH),
    .LED_BASE    (LB),
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD)
  ) dut (
    .CLK     (clk),
    .RESET   (rst_n),
    .bus     (bus),
    .dig_sel (dig_sel),
    .dig_val (dig_val)
  );

  logic [7:0] m_ram [DEPTH];
  logic [3:0] m_dig [ND];
  int n_vec = 0;
  int n_err = 0;
  int edges;
  bit scan_chk = 0;
  bit val_chk  = 0;
  bit rst_win  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: one call per accepted request, updates the model state.
  task automatic model_access(input bit we, input bit sz, input bit sx, input logic [15:0] a,
                              input logic [15:0] wd, output logic [15:0] rd, output bit er);
    int ai;
    int k;
    ai = int'(a);
    rd = 16'h0;
    er = 0;
    if (sz && a[0]) begin
      er = 1;
    end else if (ai < DEPTH) begin
      if (sz) rd = {m_ram[ai+1], m_ram[ai]};
      else    rd = (sx && m_ram[ai][7]) ? {8'hFF, m_ram[ai]} : {8'h00, m_ram[ai]};
      if (we) begin
        m_ram[ai] = wd[7:0];
        if (sz) m_ram[ai+1] = wd[15:8];
      end
    end else if (ai >= int'(LB) && ai < int'(LB) + ND) begin
      k  = ai - int'(LB);
      rd = {12'h000, m_dig[k]};
      if (sz && k + 1 < ND) rd[15:8] = {4'h0, m_dig[k+1]};
      if (we) begin
        m_dig[k] = wd[3:0];
        if (sz && k + 1 < ND) m_dig[k+1] = wd[11:8];
      end
    end else begin
      er = 1;
    end
  endtask

  task automatic access(input bit we, input bit sz, input bit sx, input logic [15:0] a,
                        input logic [15:0] wd, input string tag, output logic [15:0] got);
    logic [15:0] erd;
    bit          eer;
    model_access(we, sz, sx, a, wd, erd, eer);
    @(negedge clk);
    check({tag, ".ready"}, bus.ready, 1);
    check({tag, ".idle_rv"}, bus.rvalid, 0);
    bus.req = 1; bus.we = we; bus.size = sz; bus.sext = sx; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.req = 0; bus.we = 1'($urandom); bus.addr = 16'($urandom); bus.wdata = 16'($urandom);
    @(negedge clk);
    check({tag, ".rvalid"}, bus.rvalid, 1);
    check({tag, ".err"}, bus.err, 32'(eer));
    if (!we || eer) check({tag, ".rdata"}, bus.rdata, erd);
    got = bus.rdata;
  endtask

  function automatic logic [31:0] exp_sel();
    return 32'(1) << ((edges / SD) % ND);
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;

  always @(negedge clk) begin
    if (scan_chk) begin
      check("dig_sel", dig_sel, exp_sel());
      if (val_chk) check("dig_val", dig_val, 32'(m_dig[(edges / SD) % ND]));
    end
    if (rst_win) check("rst.rvalid", bus.rvalid, 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got, erd;
    bit          eer;
    int          acc, rv;
    bit          exp_rdy;
    logic [15:0] a;
    int          r;

    bus.req = 0; bus.we = 0; bus.size = 0; bus.sext = 0; bus.addr = 0; bus.wdata = 0;
    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ready", bus.ready, 1);
    check("rst.rvalid", bus.rvalid, 0);
    check("rst.err", bus.err, 0);
    check("rst.rdata", bus.rdata, 0);
    check("rst.dig_sel", dig_sel, 1);
    check("rst.dig_val", dig_val, 0);
    rst_n = 1'b1;
    scan_chk = 1;

    for (int i = 0; i < DEPTH; i += 2) access(1, 1, 0, 16'(i), 16'($urandom), "fill", got);

    access(1, 1, 0, 16'h0010, 16'hA5C3, "hw_wr", got);
    access(0, 1, 0, 16'h0010, 16'h0000, "hw_rd", got);
    check("hw_rd.val", got, 16'hA5C3);
    access(0, 0, 1, 16'h0011, 16'h0000, "sx_rd", got);
    check("sx_rd.val", got, 16'hFFA5);
    access(0, 0, 0, 16'h0011, 16'h0000, "zx_rd", got);
    check("zx_rd.val", got, 16'h00A5);

    access(1, 1, 0, 16'h0011, 16'h1234, "mis_wr", got);
    access(0, 1, 0, 16'h0010, 16'h0000, "mis_chk", got);
    check("mis_chk.val", got, 16'hA5C3);

    access(1, 0, 0, 16'h0100, 16'h0055, "oor_wr", got);
    access(0, 0, 0, 16'h0100, 16'h0000, "oor_rd", got);
    check("oor_rd.val", got, 16'h0000);

    access(1, 0, 0, LB + 16'd0, 16'h00F3, "dig0", got);
    access(1, 0, 0, LB + 16'd1, 16'h0007, "dig1", got);
    access(1, 0, 0, LB + 16'd2, 16'h0009, "dig2", got);
    access(1, 0, 0, LB + 16'd3, 16'h000E, "dig3", got);
    access(0, 1, 0, LB + 16'd0, 16'h0000, "dig_hw", got);
    check("dig_hw.val", got, 16'h0703);
    access(0, 0, 1, LB + 16'd3, 16'h0000, "dig_sx", got);
    check("dig_sx.val", got, 16'h000E);
    repeat (2) @(negedge clk);
    val_chk = 1;
    repeat (2 * SD * ND + 3) @(negedge clk);
    val_chk = 0;

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      a = 16'($urandom_range(0, DEPTH - 1));
      else if (r < 8) a = LB + 16'($urandom_range(0, ND + 1));
      else if (r < 9) a = 16'($urandom_range(16'h0100, 16'h1FFF));
      else            a = 16'($urandom_range(16'h2004, 16'hFFFF));
      access(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), "rnd", got);
    end
    repeat (2) @(negedge clk);
    val_chk = 1;
    repeat (SD * ND + 1) @(negedge clk);
    val_chk = 0;

    // req held high: accept every other cycle, garbage on the bus during RESP.
    a = 16'h0020;
    model_access(0, 1, 0, a, 16'h0, erd, eer);
    acc = 0; rv = 0; exp_rdy = 1;
    @(negedge clk);
    bus.req = 1; bus.we = 0; bus.size = 1; bus.sext = 0; bus.addr = a;
    for (int c = 0; c < 10; c++) begin
      check("hold.ready", bus.ready, 32'(exp_rdy));
      check("hold.rvalid", bus.rvalid, 32'(!exp_rdy));
      if (bus.ready) begin
        acc++;
        bus.we = 0; bus.size = 1; bus.addr = a;
      end
      if (bus.rvalid) begin
        rv++;
        check("hold.rdata", bus.rdata, erd);
        bus.we = 1; bus.size = 0; bus.addr = 16'($urandom);
      end
      exp_rdy = !exp_rdy;
      @(negedge clk);
    end
    bus.req = 0; bus.we = 0;
    check("hold.count", rv, acc);
    check("hold.accepts", acc, 5);

    access(1, 1, 0, 16'h0040, 16'hBEEF, "pre_rst", got);
    access(1, 0, 0, LB + 16'd1, 16'h0005, "pre_dig", got);
    @(negedge clk);
    bus.req = 1; bus.we = 0; bus.size = 1; bus.addr = 16'h0040;
    @(posedge clk);
    #1;
    bus.req = 0;
    rst_n = 1'b0;
    rst_win = 1;
    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
    #1;
    check("midrst.rvalid", bus.rvalid, 0);
    check("midrst.ready", bus.ready, 1);
    check("midrst.dig_sel", dig_sel, 1);
    check("midrst.dig_val", dig_val, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_win = 0;
    access(0, 1, 0, 16'h0040, 16'h0000, "post_rst", got);
    check("post_rst.val", got, 16'hBEEF);
    access(0, 1, 0, LB + 16'd0, 16'h0000, "post_dig", got);
    check("post_dig.val", got, 16'h0000);
    repeat (2) @(negedge clk);
    val_chk = 1;
    repeat (SD * ND) @(negedge clk);
    val_chk = 0;
    scan_chk = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
